// File: rtl/machine_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// machine_pkg : machine status codes and host sequencer state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package machine_pkg;

   localparam logic [1:0] MST_IDLE = 2'b00;
   localparam logic [1:0] MST_LOAD = 2'b10;
   localparam logic [1:0] MST_PROC = 2'b01;
   localparam logic [1:0] MST_READ = 2'b11;

   // Shared timer width: must hold TIMEOUT-1 for the largest timeout.
   localparam int c_TMO_W = 21;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      LHOLD = 3'd2,
      PROC  = 3'd3,
      RWAIT = 3'd4,
      ROUT  = 3'd5
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/machine_host_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// machine_host_sequencer_if : pixel streams, job control and machine bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface machine_host_sequencer_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              start;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              busy;
   logic              done;
   logic              err;
   logic [1:0]        m_status;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   logic              m_end_process;
   logic [DATA_W-1:0] m_out;

   modport master (
      input  start, in_valid, in_data, out_ready, m_end_process, m_out,
      output in_ready, out_valid, out_data, busy, done, err, m_status, m_addr, m_data
   );

   modport slave (
      output start, in_valid, in_data, out_ready, m_end_process, m_out,
      input  in_ready, out_valid, out_data, busy, done, err, m_status, m_addr, m_data
   );
endinterface
`default_nettype wire

// File: rtl/seq_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_timer : loadable down-counter that parks at zero, with a zero flag
// Rev 1.0
// ---------------------------------------------------------------------------
module seq_timer #(
   parameter int WIDTH = 21
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_value,
   output logic             o_zero
);
   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - WIDTH'(1);
      end
   end

   assign o_zero = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/machine_host_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// machine_host_sequencer : load / process / read sequencer for the machine
// Rev 1.0
// ---------------------------------------------------------------------------
module machine_host_sequencer
   import machine_pkg::*;
#(
   parameter int IMG_W   = 256,
   parameter int OUT_W   = 127,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int RD_LAT  = 2,
   parameter int TIMEOUT = 1048576
) (
   input  logic                     clk,
   input  logic                     rst,
   machine_host_sequencer_if.master bus
);
   localparam logic [ADDR_W-1:0]  c_LAST_IN  = ADDR_W'(IMG_W * IMG_W - 1);
   localparam logic [ADDR_W-1:0]  c_LAST_OUT = ADDR_W'(OUT_W * OUT_W - 1);
   localparam logic [c_TMO_W-1:0] c_TMO_LOAD = c_TMO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [c_TMO_W-1:0] c_RD_LOAD  = c_TMO_W'((RD_LAT > 0) ? (RD_LAT - 1) : 0);

   seq_state_t        r_state;
   logic [ADDR_W-1:0] r_pix_cnt;
   logic              r_in_ready;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [1:0]        r_m_status;
   logic [ADDR_W-1:0] r_m_addr;
   logic [DATA_W-1:0] r_m_data;

   logic               w_tmr_load;
   logic [c_TMO_W-1:0] w_tmr_value;
   logic               w_tmr_zero;

   // One timer serves both waits: it is armed on entry to PROC and RWAIT.
   always_comb begin
      w_tmr_load  = 1'b0;
      w_tmr_value = c_TMO_LOAD;
      case (r_state)
         LHOLD: w_tmr_load = 1'b1;
         PROC: begin
            if (bus.m_end_process) begin
               w_tmr_load  = 1'b1;
               w_tmr_value = c_RD_LOAD;
            end
         end
         ROUT: begin
            if (bus.out_ready && (r_m_addr != c_LAST_OUT)) begin
               w_tmr_load  = 1'b1;
               w_tmr_value = c_RD_LOAD;
            end
         end
         default: ;
      endcase
   end

   seq_timer #(.WIDTH(c_TMO_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_tmr_load),
      .i_value (w_tmr_value),
      .o_zero  (w_tmr_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_pix_cnt   <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_m_status  <= MST_IDLE;
         r_m_addr    <= '0;
         r_m_data    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_err      <= 1'b0;
                  r_m_status <= MST_LOAD;
                  r_pix_cnt  <= '0;
                  r_in_ready <= 1'b1;
                  r_state    <= LOAD;
               end
            end
            LOAD: begin
               if (bus.in_valid) begin
                  r_m_addr  <= r_pix_cnt;
                  r_m_data  <= bus.in_data;
                  r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
                  if (r_pix_cnt == c_LAST_IN) begin
                     r_in_ready <= 1'b0;
                     r_state    <= LHOLD;
                  end
               end
            end
            LHOLD: begin
               r_m_status <= MST_PROC;
               r_state    <= PROC;
            end
            PROC: begin
               // end_process takes priority over a timeout in the same cycle.
               if (bus.m_end_process) begin
                  r_m_status <= MST_READ;
                  r_m_addr   <= '0;
                  r_state    <= RWAIT;
               end else if ((TIMEOUT != 0) && w_tmr_zero) begin
                  r_err      <= 1'b1;
                  r_busy     <= 1'b0;
                  r_m_status <= MST_IDLE;
                  r_state    <= IDLE;
               end
            end
            RWAIT: begin
               if (w_tmr_zero) begin
                  r_out_data  <= bus.m_out;
                  r_out_valid <= 1'b1;
                  r_state     <= ROUT;
               end
            end
            ROUT: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  if (r_m_addr == c_LAST_OUT) begin
                     r_m_status <= MST_IDLE;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_state    <= IDLE;
                  end else begin
                     r_m_addr <= r_m_addr + ADDR_W'(1);
                     r_state  <= RWAIT;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.err       = r_err;
   assign bus.m_status  = r_m_status;
   assign bus.m_addr    = r_m_addr;
   assign bus.m_data    = r_m_data;
endmodule
`default_nettype wire
